// File: rtl/if_fetch_pkg.sv
// Shared constants and hold-level encodings for the instruction fetch unit.
// Build option: define IF_FETCH_BYPASS_EN to let a returning word skip an empty prefetch FIFO.
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define Hold_None 3'b000
`define Pause_Pc  3'b001
`define Pause_If  3'b010
`define Pause_Id  3'b011
`define INST_NOP  32'h0000_0013
// IF_FETCH_BYPASS_EN: when defined, a fresh response drives inst_o in its own cycle if the FIFO is empty.
`endif

package if_fetch_pkg;
   localparam logic [2:0]  HOLD_NONE     = `Hold_None;
   localparam logic [2:0]  HOLD_PAUSE_PC = `Pause_Pc;
   localparam logic [2:0]  HOLD_PAUSE_IF = `Pause_If;
   localparam logic [2:0]  HOLD_PAUSE_ID = `Pause_Id;
   localparam logic [31:0] INST_NOP_WORD = `INST_NOP;
   // FIFO entry layout: {inst[63:32], addr[31:0]}
   localparam int          ENTRY_W       = 64;
endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of {inst, addr} entries; power-of-two depth, flush clears all entries.
module if_fifo
   import if_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_flush,
   input  logic [ENTRY_W-1:0]    i_wdata,
   output logic [ENTRY_W-1:0]    o_rdata,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW:0]        r_wr_ptr;
   logic [AW:0]        r_rd_ptr;
   logic               w_do_push;
   logic               w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches on req/gnt/rvalid, buffers returns for IF/ID.
// Build option: IF_FETCH_BYPASS_EN enables the same-cycle path from an empty FIFO to the outputs.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);
   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic          r_active;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_credit;
   logic [CW-1:0] r_discard;

   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic [CW-1:0]      w_fifo_count;
   logic [ENTRY_W-1:0] w_fifo_rdata;
   logic               w_hold_ok;
   logic               w_pop;
   logic               w_drop;
   logic               w_bypass;
   logic               w_push;
   logic               w_accept;
   logic [CW-1:0]      w_credit_eff;
   logic [CW-1:0]      w_credit_next;
   logic [CW-1:0]      w_inflight;
   logic [CW-1:0]      w_discard_on_jump;
   logic [31:0]        w_jump_target;

   assign w_hold_ok     = (hold_flag_i < HOLD_PAUSE_PC);
   assign w_pop         = !w_fifo_empty && w_hold_ok && !jump_flag_i;
   assign w_drop        = ibus_rvalid_i && (r_discard != '0);
`ifdef IF_FETCH_BYPASS_EN
   assign w_bypass      = w_fifo_empty && ibus_rvalid_i && !w_drop && w_hold_ok && !jump_flag_i;
`else
   assign w_bypass      = 1'b0;
`endif
   assign w_push        = ibus_rvalid_i && !w_drop && !w_bypass && !jump_flag_i && !w_fifo_full;

   // A pop this cycle frees a slot immediately, so a full unit can keep one request per cycle.
   assign w_credit_eff  = r_credit - CW'(w_pop);
   assign ibus_req_o    = r_active && !jump_flag_i && (w_credit_eff < DEPTH_C);
   assign ibus_addr_o   = r_fetch_pc;
   assign w_accept      = ibus_req_o && ibus_gnt_i;

   // Responses still owed by the bus; no request is accepted in a jump cycle.
   assign w_inflight        = r_credit - w_fifo_count;
   assign w_discard_on_jump = w_inflight - CW'(ibus_rvalid_i);
   assign w_jump_target     = jump_addr_i & 32'hFFFF_FFFC;
   assign w_credit_next     = r_credit + CW'(w_accept) - CW'(w_pop) - CW'(w_drop) - CW'(w_bypass);

   if_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (jump_flag_i),
      .i_wdata ({ibus_rdata_i, r_resp_pc}),
      .o_rdata (w_fifo_rdata),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full),
      .o_count (w_fifo_count)
   );

   always_comb begin
      inst_o       = INST_NOP_WORD;
      inst_addr_o  = 32'h0;
      inst_valid_o = 1'b0;
      if (w_pop) begin
         inst_o       = w_fifo_rdata[63:32];
         inst_addr_o  = w_fifo_rdata[31:0];
         inst_valid_o = 1'b1;
      end
`ifdef IF_FETCH_BYPASS_EN
      else if (w_bypass) begin
         inst_o       = ibus_rdata_i;
         inst_addr_o  = r_resp_pc;
         inst_valid_o = 1'b1;
      end
`endif
   end

   // r_resp_pc tracks the address of the next live response; fetches after a redirect are sequential.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active   <= 1'b0;
         r_fetch_pc <= RESET_ADDR;
         r_resp_pc  <= RESET_ADDR;
         r_credit   <= '0;
         r_discard  <= '0;
      end else begin
         r_active <= 1'b1;
         if (jump_flag_i) begin
            r_fetch_pc <= w_jump_target;
            r_resp_pc  <= w_jump_target;
            r_discard  <= w_discard_on_jump;
            r_credit   <= w_discard_on_jump;
         end else begin
            if (w_accept)            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push || w_bypass)  r_resp_pc  <= r_resp_pc + 32'd4;
            if (w_drop)              r_discard  <= r_discard - 1'b1;
            r_credit <= w_credit_next;
         end
      end
   end
endmodule
